threshold_scanner: RTL and testbench
====================================

THRESHOLD_SCANNER -- requirements
Module: threshold_scanner

Interface
REQ-001 SHALL have parameter WIDTH_BITS, default 8, meaning log2 of image width (256).
REQ-002 SHALL have parameter HEIGHT_BITS, default 8, meaning log2 of image height (256).
REQ-003 SHALL have parameter S_SHIFT, default 5, meaning log2 of the running-average window (32 px).
REQ-004 SHALL have parameter BIAS_SHIFT, default 3, meaning threshold bias of sum>>BIAS_SHIFT (12.5 % below the mean).
REQ-005 SHALL have port clock, input, 1 bit, the single system clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port iStart, input, 1 bit, pulse that requests one full-frame scan.
REQ-008 SHALL have port oRdcol, output, WIDTH_BITS, read X coordinate to the middle RAM controller.
REQ-009 SHALL have port oRdrow, output, HEIGHT_BITS, read Y coordinate to the middle RAM controller.
REQ-010 SHALL have port iRddata, input, 8 bits, middle RAM pixel, valid one cycle after its address.
REQ-011 SHALL have port oWren, output, 1 bit, write strobe to the result RAM.
REQ-012 SHALL have port oWrcol, output, WIDTH_BITS, write X coordinate.
REQ-013 SHALL have port oWrrow, output, HEIGHT_BITS, write Y coordinate.
REQ-014 SHALL have port oWrdata, output, 8 bits, binarised pixel, 8'hFF or 8'h00.
REQ-015 SHALL have port oBusy, output, 1 bit, high while a scan is in progress.
REQ-016 SHALL have port oDone, output, 1 bit, one-cycle pulse at scan completion.

Function
REQ-017 SHALL implement states IDLE, SCAN, DRAIN, DONE; IDLE->SCAN on iStart=1; SCAN->DRAIN after the last address (all-ones col and row); DRAIN->DONE after the last write; DONE->IDLE unconditionally.
REQ-018 SHALL ignore iStart in any state other than IDLE, including the DONE cycle.
REQ-019 SHALL, with c0 = first cycle after iStart is accepted, drive the address of pixel k (raster order, col fastest) during cycle c0+k for k = 0..N-1, N = 2^(WIDTH_BITS+HEIGHT_BITS).
REQ-020 SHALL hold oRdcol/oRdrow at their last value outside SCAN.
REQ-021 SHALL assert oWren for pixel k in cycle c0+k+2 only, with oWrcol/oWrrow equal to that pixel's coordinates (fixed latency 2, no gaps).
REQ-022 SHALL keep a per-row running sum s, width 8+S_SHIFT bits, reloaded to 128<<S_SHIFT for the col-0 pixel of every row.
REQ-023 SHALL, for pixel p with prior sum s, output 8'hFF iff (p<<S_SHIFT) > s - (s>>BIAS_SHIFT), else 8'h00, compared unsigned in 8+S_SHIFT bits.
REQ-024 SHALL update s_next = s - (s>>S_SHIFT) + p after each pixel; the result SHALL never overflow 8+S_SHIFT bits.
REQ-025 SHALL assert oBusy from c0 through c0+N+1 inclusive, and oDone for cycle c0+N+2 only.
REQ-026 SHALL wrap row/column counters to zero at end of frame with no extra read issued.

Reset
REQ-027 SHALL, on reset=1 asynchronously, force state IDLE, oWren=0, oBusy=0, oDone=0, oWrdata=0, all coordinate outputs 0, running sum 128<<S_SHIFT.
REQ-028 SHALL, on reset mid-scan, abandon the frame without a further write or oDone pulse; the next iStart after release SHALL start from pixel (0,0).

Verification (WIDTH_BITS=2, HEIGHT_BITS=2, S_SHIFT=2, BIAS_SHIFT=3, N=16, 1-cycle RAM model)
REQ-029 SHALL check: all pixels 200, iStart pulse -> 16 writes of 8'hFF in cycles c0+2..c0+17, oDone at c0+18, oBusy high c0..c0+17.
REQ-030 SHALL check: all pixels 100 -> col 0 of each row 8'h00 (400 <= 448); s after col 0 = 484.
REQ-031 SHALL check: all pixels 0 -> 16 writes of 8'h00, coordinates in raster order (0,0),(1,0)...(3,3).
REQ-032 SHALL check: iStart held high for the whole scan and during DONE -> exactly one scan, one oDone, then a new scan only if iStart is high while in IDLE.
REQ-033 SHALL check: reset asserted at c0+7 -> oWren/oBusy low in the same cycle, no oDone; restart produces a full correct 16-pixel frame.
REQ-034 SHALL check: row 0 = 0,0,0,255 -> outputs 00,00,00,FF; row 1 starts from a reloaded sum of 512.

Source files
------------

// File: rtl/threshold_scanner.sv
// Purpose : adaptive binarisation of one frame; each pixel is compared to a
//           per-row running average and written back as 8'hFF / 8'h00.
// Latency : write for pixel k two cycles after its read address; one pixel per cycle.
// Backpressure: none -- the read RAM answers in one cycle and the result RAM
//           accepts every cycle, so the scan streams without stalls.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   iStart            request one full-frame scan (honoured only when idle)
//   oRdcol/oRdrow     read coordinates to the middle RAM
//   iRddata           pixel from the middle RAM, one cycle after its address
//   oWren             result RAM write strobe
//   oWrcol/oWrrow     result RAM write coordinates
//   oWrdata           binarised pixel (8'hFF above threshold, else 8'h00)
//   oBusy             high while a scan is in progress
//   oDone             one-cycle pulse when the last result has been written
module threshold_scanner #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int S_SHIFT     = 5,
    parameter int BIAS_SHIFT  = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iStart,
    output logic [WIDTH_BITS-1:0]  oRdcol,
    output logic [HEIGHT_BITS-1:0] oRdrow,
    input  logic [7:0]             iRddata,
    output logic                   oWren,
    output logic [WIDTH_BITS-1:0]  oWrcol,
    output logic [HEIGHT_BITS-1:0] oWrrow,
    output logic [7:0]             oWrdata,
    output logic                   oBusy,
    output logic                   oDone
);

    // Running sum holds roughly 2^S_SHIFT pixels' worth of intensity.
    localparam int SW = 8 + S_SHIFT;
    localparam logic [SW-1:0] SUM_INIT = SW'(128 << S_SHIFT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q;

    // Read address generator
    logic [WIDTH_BITS-1:0]  rdcol_q;
    logic [HEIGHT_BITS-1:0] rdrow_q;

    // Stage 1: coordinates of the pixel whose data is on iRddata this cycle
    logic                   pix_vld_q;
    logic [WIDTH_BITS-1:0]  pixcol_q;
    logic [HEIGHT_BITS-1:0] pixrow_q;

    // Running sum carried along the row
    logic [SW-1:0]          sum_q;
    logic [SW-1:0]          sum_d;

    // Stage 2: registered write port
    logic                   wren_q;
    logic [WIDTH_BITS-1:0]  wrcol_q;
    logic [HEIGHT_BITS-1:0] wrrow_q;
    logic [7:0]             wrdata_q;

    logic                   busy_q;
    logic                   done_q;

    // Threshold datapath
    logic [SW-1:0]          sum_base;
    logic [SW-1:0]          thr;
    logic [SW-1:0]          pix_scaled;
    logic                   hit;
    logic                   last_rd;
    logic                   last_wr;

    always_comb begin
        // Column 0 starts from mid-grey so every row adapts independently.
        sum_base   = (pixcol_q == '0) ? SUM_INIT : sum_q;
        // Threshold sits 1/2^BIAS_SHIFT below the running mean.
        thr        = sum_base - (sum_base >> BIAS_SHIFT);
        pix_scaled = SW'(iRddata) << S_SHIFT;
        hit        = (pix_scaled > thr);
        // Exponential average: drop 1/2^S_SHIFT of the sum, add the new pixel.
        // Bounded by 255<<S_SHIFT, so it always fits SW bits.
        sum_d      = sum_base - (sum_base >> S_SHIFT) + SW'(iRddata);
    end

    assign last_rd = (rdcol_q == '1) && (rdrow_q == '1);
    assign last_wr = wren_q && (wrcol_q == '1) && (wrrow_q == '1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rdcol_q   <= '0;
            rdrow_q   <= '0;
            pix_vld_q <= 1'b0;
            pixcol_q  <= '0;
            pixrow_q  <= '0;
            sum_q     <= SUM_INIT;
            wren_q    <= 1'b0;
            wrcol_q   <= '0;
            wrrow_q   <= '0;
            wrdata_q  <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // Pipeline: address issued in SCAN -> data next cycle -> write after.
            pix_vld_q <= (state_q == SCAN);
            pixcol_q  <= rdcol_q;
            pixrow_q  <= rdrow_q;

            wren_q <= pix_vld_q;
            if (pix_vld_q) begin
                wrcol_q  <= pixcol_q;
                wrrow_q  <= pixrow_q;
                wrdata_q <= hit ? 8'hFF : 8'h00;
                sum_q    <= sum_d;
            end

            done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (iStart) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                        rdcol_q <= '0;
                        rdrow_q <= '0;
                    end
                end
                SCAN: begin
                    // Counters wrap naturally to (0,0) after the last pixel,
                    // which is also the value they hold while not scanning.
                    rdcol_q <= rdcol_q + 1'b1;
                    if (rdcol_q == '1) begin
                        rdrow_q <= rdrow_q + 1'b1;
                    end
                    if (last_rd) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave once the final pixel's write is on the port.
                    if (last_wr) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oRdcol  = rdcol_q;
    assign oRdrow  = rdrow_q;
    assign oWren   = wren_q;
    assign oWrcol  = wrcol_q;
    assign oWrrow  = wrrow_q;
    assign oWrdata = wrdata_q;
    assign oBusy   = busy_q;
    assign oDone   = done_q;

endmodule

// File: tb/tb_threshold_scanner.sv
// Directed bench for threshold_scanner on a 4x4 frame with a one-cycle RAM model.
module tb_threshold_scanner;

    localparam int WB   = 2;
    localparam int HB   = 2;
    localparam int NPIX = 16;

    logic          clock;
    logic          reset;
    logic          iStart;
    logic [WB-1:0] oRdcol;
    logic [HB-1:0] oRdrow;
    logic [7:0]    iRddata;
    logic          oWren;
    logic [WB-1:0] oWrcol;
    logic [HB-1:0] oWrrow;
    logic [7:0]    oWrdata;
    logic          oBusy;
    logic          oDone;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] img     [NPIX];
    logic [7:0] exp_tab [NPIX];

    threshold_scanner #(
        .WIDTH_BITS (WB),
        .HEIGHT_BITS(HB),
        .S_SHIFT    (2),
        .BIAS_SHIFT (3)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .iStart (iStart),
        .oRdcol (oRdcol),
        .oRdrow (oRdrow),
        .iRddata(iRddata),
        .oWren  (oWren),
        .oWrcol (oWrcol),
        .oWrrow (oWrrow),
        .oWrdata(oWrdata),
        .oBusy  (oBusy),
        .oDone  (oDone)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Middle RAM: data for an address appears one cycle later.
    always @(posedge clock) iRddata <= img[{oRdrow, oRdcol}];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [7:0] pix, input logic [7:0] res);
        for (int i = 0; i < NPIX; i++) begin
            img[i]     = pix;
            exp_tab[i] = res;
        end
    endtask

    task automatic set_row(input int r,
                           input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] p2, input logic [7:0] p3,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
        img[r*4+0] = p0; img[r*4+1] = p1; img[r*4+2] = p2; img[r*4+3] = p3;
        exp_tab[r*4+0] = e0; exp_tab[r*4+1] = e1;
        exp_tab[r*4+2] = e2; exp_tab[r*4+3] = e3;
    endtask

    // One scan with cycle-exact checks; cyc counts from c0.
    task automatic run_scan(input string name, input bit hold);
        int k;
        int ndone;
        @(posedge clock); #1 iStart = 1'b1;
        @(posedge clock); #1 if (!hold) iStart = 1'b0;
        for (int cyc = 0; cyc <= NPIX + 3; cyc++) begin
            @(negedge clock);
            check({name, ".busy"}, 32'(oBusy), 32'(cyc <= NPIX + 1));
            check({name, ".done"}, 32'(oDone), 32'(cyc == NPIX + 2));
            check({name, ".wren"}, 32'(oWren), 32'(cyc >= 2 && cyc <= NPIX + 1));
            if (cyc < NPIX) begin
                check({name, ".rdcol"}, 32'(oRdcol), 32'(cyc % 4));
                check({name, ".rdrow"}, 32'(oRdrow), 32'(cyc / 4));
            end else begin
                check({name, ".rdcol_hold"}, 32'(oRdcol), 32'd0);
                check({name, ".rdrow_hold"}, 32'(oRdrow), 32'd0);
            end
            if (cyc >= 2 && cyc <= NPIX + 1) begin
                k = cyc - 2;
                check({name, ".wrcol"}, 32'(oWrcol), 32'(k % 4));
                check({name, ".wrrow"}, 32'(oWrrow), 32'(k / 4));
                check({name, ".wrdata"}, 32'(oWrdata), 32'(exp_tab[k]));
            end
        end
        if (hold) begin
            // iStart still high in IDLE -> a second scan begins next cycle.
            @(negedge clock);
            check({name, ".restart_busy"}, 32'(oBusy), 32'd1);
            iStart = 1'b0;
            ndone = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clock);
                if (oDone) ndone++;
            end
            check({name, ".second_done_count"}, 32'(ndone), 32'd1);
            check({name, ".idle_after"}, 32'(oBusy), 32'd0);
        end
    endtask

    initial begin
        int nwr;
        int ndone;
        reset  = 1'b0;
        iStart = 1'b0;
        fill(8'd0, 8'h00);
        #2 reset = 1'b1;
        #1;
        check("rst.wren",   32'(oWren),   32'd0);
        check("rst.busy",   32'(oBusy),   32'd0);
        check("rst.done",   32'(oDone),   32'd0);
        check("rst.wrdata", 32'(oWrdata), 32'd0);
        check("rst.rdcol",  32'(oRdcol),  32'd0);
        check("rst.rdrow",  32'(oRdrow),  32'd0);
        check("rst.wrcol",  32'(oWrcol),  32'd0);
        check("rst.wrrow",  32'(oWrrow),  32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b0;

        // Bright flat frame: every pixel clears the threshold.
        fill(8'd200, 8'hFF);
        run_scan("p200", 1'b0);

        // Flat 100: 400<=448, then 400<=424, 400<=406, finally 400>392.
        fill(8'd100, 8'h00);
        for (int r = 0; r < 4; r++) exp_tab[r*4+3] = 8'hFF;
        run_scan("p100", 1'b0);

        fill(8'd0, 8'h00);
        run_scan("p0", 1'b0);

        // Row 0: thresholds 448,336,252,189 -> only the 255 passes.
        // Row 1: reloaded 512 -> 100 fails; s=484 thr=424, 107*4=428 passes.
        //        Without the reload the 100 would meet thr=365 and pass.
        set_row(0, 8'd0,   8'd0,   8'd0,   8'd255, 8'h00, 8'h00, 8'h00, 8'hFF);
        set_row(1, 8'd100, 8'd107, 8'd0,   8'd255, 8'h00, 8'hFF, 8'h00, 8'hFF);
        set_row(2, 8'd100, 8'd100, 8'd100, 8'd100, 8'h00, 8'h00, 8'h00, 8'hFF);
        set_row(3, 8'd200, 8'd200, 8'd200, 8'd200, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_scan("mixed", 1'b0);

        // iStart held through the scan and DONE.
        fill(8'd200, 8'hFF);
        run_scan("hold", 1'b1);

        // Reset in the middle of a scan.
        @(posedge clock); #1 iStart = 1'b1;
        @(posedge clock); #1 iStart = 1'b0;
        for (int cyc = 0; cyc <= 7; cyc++) @(negedge clock);
        check("midrst.busy_before", 32'(oBusy), 32'd1);
        check("midrst.wren_before", 32'(oWren), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("midrst.wren", 32'(oWren), 32'd0);
        check("midrst.busy", 32'(oBusy), 32'd0);
        check("midrst.rdcol", 32'(oRdcol), 32'd0);
        @(negedge clock) reset = 1'b0;
        nwr = 0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (oWren) nwr++;
            if (oDone) ndone++;
        end
        check("midrst.no_writes", 32'(nwr), 32'd0);
        check("midrst.no_done", 32'(ndone), 32'd0);
        set_row(0, 8'd0,   8'd0,   8'd0,   8'd255, 8'h00, 8'h00, 8'h00, 8'hFF);
        set_row(1, 8'd100, 8'd107, 8'd0,   8'd255, 8'h00, 8'hFF, 8'h00, 8'hFF);
        run_scan("after_rst", 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
